// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared state encoding, chunk codes and legality check for serial_magnitude_cmp
package cmp_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Chunk result codes as {F1,F2,F3}
    localparam logic [2:0] CODE_GT = 3'b100;
    localparam logic [2:0] CODE_EQ = 3'b010;
    localparam logic [2:0] CODE_LT = 3'b001;

    // A chunk code is legal only when exactly one of F1/F2/F3 is set
    function automatic logic code_legal(input logic [2:0] code);
        return (code == CODE_GT) || (code == CODE_EQ) || (code == CODE_LT);
    endfunction

endpackage

// File: rtl/cmp_chunk_counter.sv
// rtl/cmp_chunk_counter.sv - chunk counter with clear, enable and terminal-count flag
module cmp_chunk_counter
    import cmp_pkg::*;
#(
    parameter int N_CHUNKS = 4,
    parameter int CNT_W    = $clog2(N_CHUNKS) + 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [CNT_W-1:0] cnt_q;

    // Count accepted chunks; clear has priority over enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Flags the counter value of the final chunk of a word
    assign tc_o = (cnt_q == CNT_W'(N_CHUNKS - 1));

endmodule

// File: rtl/serial_magnitude_cmp.sv
// rtl/serial_magnitude_cmp.sv - serial MSB-first word comparator over 2-bit chunk results (option: CMP_EARLY_DONE_EN)
module serial_magnitude_cmp
    import cmp_pkg::*;
#(
    parameter int N_CHUNKS = 4,
    localparam int CNT_W   = $clog2(N_CHUNKS) + 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic in_valid,
    output logic in_ready,
    input  logic F1,
    input  logic F2,
    input  logic F3,
    output logic res_valid,
    input  logic res_ready,
    output logic gt,
    output logic eq,
    output logic lt,
    output logic err,
    output logic busy
);

    logic [1:0] state_q, state_d;
    logic       lock_q, lock_d;
    logic       gt_lat_q, gt_lat_d;
    logic       lt_lat_q, lt_lat_d;
    logic       err_q, err_d;

    logic [2:0] code;
    logic       xfer;
    logic       legal;
    logic       decisive;
    logic       cnt_clr;
    logic       last_chunk;

    assign code     = {F1, F2, F3};
    assign xfer     = (state_q == ST_RUN) && in_valid;
    assign legal    = code_legal(code);
    assign decisive = xfer && legal && (code != CODE_EQ);
    assign cnt_clr  = (state_q == ST_IDLE) && start;

    cmp_chunk_counter #(
        .N_CHUNKS (N_CHUNKS),
        .CNT_W    (CNT_W)
    ) u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr),
        .en_i  (xfer),
        .tc_o  (last_chunk)
    );

    // Next-state and result-latch update; the first decisive chunk wins
    always_comb begin
        state_d  = state_q;
        lock_d   = lock_q;
        gt_lat_d = gt_lat_q;
        lt_lat_d = lt_lat_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    lock_d   = 1'b0;
                    gt_lat_d = 1'b0;
                    lt_lat_d = 1'b0;
                    err_d    = 1'b0;
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    if (!legal) begin
                        err_d = 1'b1;
                    end
                    if (decisive && !lock_q) begin
                        lock_d   = 1'b1;
                        gt_lat_d = (code == CODE_GT);
                        lt_lat_d = (code == CODE_LT);
                    end
                    if (last_chunk) begin
                        state_d = ST_DONE;
                    end
`ifdef CMP_EARLY_DONE_EN
                    // Remaining chunks cannot change a decided result
                    if (decisive) begin
                        state_d = ST_DONE;
                    end
`endif
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d  = ST_IDLE;
                    lock_d   = 1'b0;
                    gt_lat_d = 1'b0;
                    lt_lat_d = 1'b0;
                    err_d    = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            lock_q   <= 1'b0;
            gt_lat_q <= 1'b0;
            lt_lat_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lock_q   <= lock_d;
            gt_lat_q <= gt_lat_d;
            lt_lat_q <= lt_lat_d;
            err_q    <= err_d;
        end
    end

    assign in_ready  = (state_q == ST_RUN);
    assign res_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign err       = err_q;
    assign gt        = res_valid && !err_q && lock_q && gt_lat_q;
    assign lt        = res_valid && !err_q && lock_q && lt_lat_q;
    assign eq        = res_valid && !err_q && !lock_q;

endmodule

// File: tb/tb_serial_magnitude_cmp.sv
// tb/tb_serial_magnitude_cmp.sv - self-checking bench for serial_magnitude_cmp (honours CMP_EARLY_DONE_EN)
module tb_serial_magnitude_cmp;

    localparam int N = 4;
`ifdef CMP_EARLY_DONE_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic F1 = 1'b0;
    logic F2 = 1'b0;
    logic F3 = 1'b0;
    logic res_ready = 1'b0;
    logic in_ready, res_valid, gt, eq, lt, err, busy;

    int errors = 0;
    int checks = 0;

    serial_magnitude_cmp #(.N_CHUNKS(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .F1        (F1),
        .F2        (F2),
        .F3        (F3),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .gt        (gt),
        .eq        (eq),
        .lt        (lt),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase plus the list of chunks accepted so far
    int         m_phase = 0;
    int         m_n = 0;
    logic [2:0] m_chunks [64];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_n     <= 0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_phase <= 1;
                    m_n     <= 0;
                end
                1: if (in_valid) begin
                    m_chunks[m_n] <= {F1, F2, F3};
                    m_n           <= m_n + 1;
                    if (m_n + 1 == N)
                        m_phase <= 2;
                    if (EARLY && $countones({F1, F2, F3}) == 1 && !F2)
                        m_phase <= 2;
                end
                default: if (res_ready) begin
                    m_phase <= 0;
                    m_n     <= 0;
                end
            endcase
        end
    end

    // Word result from the accepted chunks: {gt,eq,lt,err}
    function automatic logic [3:0] scan(input int n);
        logic e, found, g, l;
        e = 1'b0; found = 1'b0; g = 1'b0; l = 1'b0;
        for (int i = 0; i < n; i++) begin
            if ($countones(m_chunks[i]) != 1)
                e = 1'b1;
            else if (!found && !m_chunks[i][1]) begin
                found = 1'b1;
                g = m_chunks[i][2];
                l = m_chunks[i][0];
            end
        end
        if (e) return 4'b0001;
        return {g, !found, l, 1'b0};
    endfunction

    // Expected {in_ready,res_valid,busy,gt,eq,lt,err}
    function automatic logic [6:0] expected();
        logic [3:0] r;
        logic done;
        r = scan(m_n);
        done = (m_phase == 2);
        return {m_phase == 1, done, m_phase != 0, done & r[3], done & r[2], done & r[1], r[0]};
    endfunction

    function automatic logic [6:0] outs();
        return {in_ready, res_valid, busy, gt, eq, lt, err};
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        check("cycle_outputs", outs(), expected());
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    // Send up to n chunks (MSB first) with gap stall cycles between them
    task automatic send(input logic [11:0] w, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            {F1, F2, F3} = w[11-3*i -: 3];
            in_valid = 1'b1;
            @(posedge clk); #2;
            in_valid = 1'b0;
            {F1, F2, F3} = 3'b111;
            if (!in_ready) break;
            if (i < n - 1) repeat (gap) begin @(posedge clk); #2; end
        end
    endtask

    // Result must appear the cycle after the last transfer; exp is {gt,eq,lt,err}
    task automatic res_check(input string name, input logic [3:0] exp);
        @(negedge clk);
        check(name, {2'b00, res_valid, gt, eq, lt, err}, {2'b00, 1'b1, exp});
        check({name, "_model"}, {2'b00, expected()[5], expected()[3:0]}, {2'b00, 1'b1, exp});
    endtask

    task automatic realign();
        @(posedge clk); #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        res_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", outs(), 7'b0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        realign();

        // Decisive GT in the third chunk
        do_start();
        send(12'b010_010_100_001, 4, 0);
        res_check("s1_gt", 4'b1000);
        @(negedge clk);
        check("s1_release", {5'b0, res_valid, busy}, 7'b0);
        realign();

        // All chunks equal; result lasts one cycle with res_ready high
        do_start();
        send(12'b010_010_010_010, 4, 0);
        res_check("s2_eq", 4'b0100);
        @(negedge clk);
        check("s2_one_cycle", {5'b0, res_valid, busy}, 7'b0);
        realign();

        // LT in first chunk with stalls between chunks
        do_start();
        send(12'b001_100_100_100, 4, 3);
        res_check("s3_lt", 4'b0010);
        realign();

        // Illegal second chunk
        do_start();
        send(12'b010_110_010_010, 4, 0);
        res_check("s4_err", 4'b0001);
        realign();

        // Backpressure in DONE with start pulses
        res_ready = 1'b0;
        do_start();
        send(12'b010_010_010_100, 4, 0);
        res_check("s5_gt", 4'b1000);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #2;
            start = (k % 2 == 0);
            @(negedge clk);
            check("s5_hold", {1'b0, res_valid, busy, gt, eq, lt, err}, 7'b0111000);
        end
        @(posedge clk); #2;
        res_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #2;
        check("s5_handshake_idle", {5'b0, res_valid, busy}, 7'b0);
        @(posedge clk); #2;
        start = 1'b0;
        check("s5_restart", {6'b0, busy}, 7'b1);
        send(12'b001_010_010_010, 4, 0);
        res_check("s5b_lt", 4'b0010);
        realign();

        // Asynchronous reset mid-transaction
        do_start();
        send(12'b010_010_010_010, 2, 0);
        #1 rst_n = 1'b0;
        #1 check("s6_async_reset", outs(), 7'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        do_start();
        send(12'b100_010_010_010, 4, 0);
        res_check("s6_gt", 4'b1000);
        realign();
        realign();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
